// File: rtl/mod2011_pkg.sv
// rtl/mod2011_pkg.sv - shared constants, types and modular add for the mod-2011 residue path
package mod2011_pkg;

    localparam int MODULUS   = 2011;
    localparam int RES_W     = 11;
    localparam int NUM_TERMS = 50;
    localparam int CNT_W     = $clog2(NUM_TERMS + 1);

    typedef logic [RES_W-1:0] residue_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } acc_state_t;

    localparam residue_t         MOD_R  = residue_t'(MODULUS);
    localparam logic [RES_W:0]   MOD_S  = (RES_W+1)'(MODULUS);

    // Both operands must already be below MODULUS, so one subtract suffices.
    function automatic residue_t mod_add(residue_t a, residue_t b);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_S) begin
            s = s - MOD_S;
        end
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod2011_add_corr.sv
// rtl/mod2011_add_corr.sv - reduces a raw 11-bit partial residue and adds it to a base modulo 2011
module mod2011_add_corr
    import mod2011_pkg::*;
(
    input  logic [RES_W-1:0] base,
    input  logic [RES_W-1:0] term,
    output logic [RES_W-1:0] sum
);

    residue_t term_red;

    // Raw terms span 0..2047, which is less than twice the modulus.
    always_comb begin
        term_red = term;
        if (term >= MOD_R) begin
            term_red = term - MOD_R;
        end
    end

    assign sum = mod_add(base, term_red);

endmodule

// File: rtl/mod2011_residue_accumulator.sv
// rtl/mod2011_residue_accumulator.sv - serial mod-2011 accumulator of chunk-LUT partial residues
// Optional frame-length check: MOD2011_ACC_LEN_CHECK_EN
module mod2011_residue_accumulator
    import mod2011_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_term,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic             out_err
);

    acc_state_t state, state_n;
    residue_t   acc, acc_n;
    residue_t   res_q, res_n;
    residue_t   base;
    residue_t   sum;
    logic       xfer;
    logic       first;

    assign out_valid = (state == ST_DONE);
    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign first     = (state != ST_ACC);
    assign base      = first ? '0 : acc;
    assign out_res   = res_q;

    mod2011_add_corr u_add_corr (
        .base (base),
        .term (in_term),
        .sum  (sum)
    );

`ifdef MOD2011_ACC_LEN_CHECK_EN
    logic [CNT_W-1:0] cnt, cnt_n, cnt_base, cnt_inc;
    logic             over, over_n, over_now;
    logic             err_q, err_n;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_TERMS);

    assign cnt_base = first ? '0 : cnt;
    // Counter saturates at the nominal length; anything beyond sets the sticky flag.
    assign over_now = (!first && over) || (cnt_base == CNT_MAX);
    assign cnt_inc  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
    assign out_err  = err_q;
`else
    assign out_err  = 1'b0;
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        res_n   = res_q;
`ifdef MOD2011_ACC_LEN_CHECK_EN
        cnt_n   = cnt;
        over_n  = over;
        err_n   = err_q;
`endif
        if (state == ST_DONE && out_ready) begin
            state_n = ST_IDLE;
        end
        if (xfer) begin
            if (in_last) begin
                res_n   = sum;
                acc_n   = '0;
                state_n = ST_DONE;
`ifdef MOD2011_ACC_LEN_CHECK_EN
                err_n   = over_now || (cnt_inc != CNT_MAX);
                cnt_n   = '0;
                over_n  = 1'b0;
`endif
            end else begin
                acc_n   = sum;
                state_n = ST_ACC;
`ifdef MOD2011_ACC_LEN_CHECK_EN
                cnt_n   = cnt_inc;
                over_n  = over_now;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            res_q <= '0;
`ifdef MOD2011_ACC_LEN_CHECK_EN
            cnt   <= '0;
            over  <= 1'b0;
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            res_q <= res_n;
`ifdef MOD2011_ACC_LEN_CHECK_EN
            cnt   <= cnt_n;
            over  <= over_n;
            err_q <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_mod2011_residue_accumulator.sv
// tb/tb_mod2011_residue_accumulator.sv - self-checking bench for mod2011_residue_accumulator
module tb_mod2011_residue_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_term = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_res;
    logic        out_err;

    int total = 0;
    int bad   = 0;
    int frame_q[$];

`ifdef MOD2011_ACC_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    mod2011_residue_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_term   (in_term),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic int model_res(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += frame_q[i];
        return int'(s % 2011);
    endfunction

    function automatic bit model_err(input int n);
        return LEN_EN && (n != 50);
    endfunction

    task automatic send_term(input int t, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_term  = 11'(t);
        in_last  = last;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < frame_q.size(); i++) send_term(frame_q[i], i == frame_q.size() - 1);
    endtask

    task automatic expect_result(input int exp_res, input bit exp_err, input string name);
        int n = 0;
        out_ready = 1'b1;
        #1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: got %0b required 1", name, out_valid);
        end
        total++;
        if (out_res !== 11'(exp_res)) begin
            bad++;
            $display("FAIL %s_res: got %0d required %0d", name, out_res, exp_res);
        end
        total++;
        if (out_err !== exp_err) begin
            bad++;
            $display("FAIL %s_err: got %0b required %0b", name, out_err, exp_err);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({out_valid, out_res, out_err, in_ready} !== {1'b0, 11'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got v=%0b r=%0d e=%0b rdy=%0b required 0 0 0 1",
                     out_valid, out_res, out_err, in_ready);
        end
    endtask

    task automatic test_wrap_latency();
        send_term(2010, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_early_valid: got %0b required 0", out_valid);
        end
        send_term(1, 1'b1);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_latency: got %0b required 1", out_valid);
        end
        expect_result(0, model_err(2), "wrap");
    endtask

    task automatic test_directed();
        frame_q = '{1000, 1000, 1000};
        send_frame();
        expect_result(989, model_err(3), "three_1000");
        frame_q = '{2047};
        send_frame();
        expect_result(36, model_err(1), "single_2047");
        frame_q = {};
        for (int i = 0; i < 50; i++) frame_q.push_back(2010);
        send_frame();
        expect_result(1961, 1'b0, "full_2010");
        frame_q.push_back(2010);
        send_frame();
        expect_result(model_res(51), model_err(51), "over_51");
    endtask

    task automatic test_back_to_back();
        frame_q = '{1000, 1000, 1000};
        send_frame();
        in_valid = 1'b1;
        in_term  = 11'd100;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== 11'd989) begin
                bad++;
                $display("FAIL stall_hold: got rdy=%0b v=%0b r=%0d required 0 1 989",
                         in_ready, out_valid, out_res);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drop: got %0b required 0", out_valid);
        end
        send_term(200, 1'b1);
        expect_result(300, model_err(2), "b2b");
    endtask

    task automatic test_reset_mid_frame();
        send_term(500, 1'b0);
        send_term(600, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_valid: got %0b required 0", out_valid);
        end
        send_term(7, 1'b1);
        expect_result(7, model_err(1), "midrst");
    endtask

    task automatic test_random();
        int len, pick, d, exp_r;
        bit exp_e;
        for (int f = 0; f < 24; f++) begin
            pick = $urandom_range(0, 3);
            case (pick)
                0: len = $urandom_range(1, 5);
                1: len = $urandom_range(49, 51);
                2: len = 50;
                default: len = $urandom_range(1, 56);
            endcase
            frame_q = {};
            for (int i = 0; i < len; i++) frame_q.push_back($urandom_range(0, 2047));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send_term(frame_q[i], i == len - 1);
            end
            exp_r = model_res(len);
            exp_e = model_err(len);
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                total++;
                if (out_valid !== 1'b1 || out_res !== 11'(exp_r)) begin
                    bad++;
                    $display("FAIL rand_hold: got v=%0b r=%0d required 1 %0d", out_valid, out_res, exp_r);
                end
                @(posedge clk); #1;
            end
            expect_result(exp_r, exp_e, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_wrap_latency();
        test_directed();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
